// File: rtl/rx_ds_char.sv
// rx_ds_char: receive-side character deserializer for the dual-rail (Rx1/Rx0)
// serial link. Frames parity, flag and data bits into characters and holds
// each completed character in a one-entry valid/ready output register.
//
// Optional feature macro: RX_PARITY_CHECK_EN
//   defined   -> parity_err_o reports odd-parity mismatch per character
//   undefined -> parity bit is consumed for framing only, parity_err_o = 0
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_PAR  | waiting for the first bit of a character (parity); idle unlimited
// ST_FLG  | parity captured, waiting for the flag bit
// ST_DAT  | shifting data bits LSB first (8 for flag 0, 2 for flag 1)
module rx_ds_char #(
  parameter int unsigned IDLE_LIMIT = 4
) (
  input  logic       RxClk,
  input  logic       RxReset,
  input  logic       Rx1,
  input  logic       Rx0,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] dat_o,
  output logic       lchar_o,
  output logic       parity_err_o,
  output logic       rail_err_o,
  output logic       overrun_o,
  output logic       abort_o
);

  typedef enum logic [1:0] {
    ST_PAR,
    ST_FLG,
    ST_DAT
  } state_t;

  localparam logic [3:0] IDLE_RELOAD = 4'(IDLE_LIMIT - 1);

  state_t     state;
  logic       r1_q;
  logic       r0_q;
  logic       flag_q;
  logic [2:0] bit_cnt;
  logic [3:0] idle_left;
  logic [7:0] data_q;
  logic [7:0] data_nxt;
  logic       last_bit;
  logic       bit_vld;
  logic       rail_bad;
  logic       perr_nxt;
`ifdef RX_PARITY_CHECK_EN
  logic       par_q;
`endif

  // Rails are registered once before framing; no synchronizer is needed.
  always_ff @(posedge RxClk or negedge RxReset) begin
    if (!RxReset) begin
      r1_q <= 1'b0;
      r0_q <= 1'b0;
    end else begin
      r1_q <= Rx1;
      r0_q <= Rx0;
    end
  end

  assign bit_vld  = r1_q ^ r0_q;
  assign rail_bad = r1_q & r0_q;
  assign last_bit = flag_q ? (bit_cnt == 3'd1) : (bit_cnt == 3'd7);

  // Data word as it will look once the current bit is placed at its position.
  always_comb begin
    data_nxt          = data_q;
    data_nxt[bit_cnt] = r1_q;
  end

`ifdef RX_PARITY_CHECK_EN
  // Parity bit XOR all data bits must be 1; unused upper bits of a link
  // character are zero and do not disturb the reduction.
  assign perr_nxt = ~(par_q ^ (^data_nxt));
`else
  assign perr_nxt = 1'b0;
`endif

  // Framing FSM with idle down-counter, output register and error pulses.
  always_ff @(posedge RxClk or negedge RxReset) begin
    if (!RxReset) begin
      state        <= ST_PAR;
      flag_q       <= 1'b0;
      bit_cnt      <= 3'd0;
      idle_left    <= 4'd0;
      data_q       <= 8'd0;
`ifdef RX_PARITY_CHECK_EN
      par_q        <= 1'b0;
`endif
      valid_o      <= 1'b0;
      dat_o        <= 8'd0;
      lchar_o      <= 1'b0;
      parity_err_o <= 1'b0;
      rail_err_o   <= 1'b0;
      overrun_o    <= 1'b0;
      abort_o      <= 1'b0;
    end else begin
      rail_err_o <= 1'b0;
      overrun_o  <= 1'b0;
      abort_o    <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;

      if (rail_bad) begin
        rail_err_o <= 1'b1;
        state      <= ST_PAR;
        idle_left  <= IDLE_RELOAD;
      end else if (bit_vld) begin
        idle_left <= IDLE_RELOAD;
        case (state)
          ST_PAR: begin
`ifdef RX_PARITY_CHECK_EN
            par_q <= r1_q;
`endif
            state <= ST_FLG;
          end
          ST_FLG: begin
            flag_q  <= r1_q;
            bit_cnt <= 3'd0;
            data_q  <= 8'd0;
            state   <= ST_DAT;
          end
          ST_DAT: begin
            data_q  <= data_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              state <= ST_PAR;
              // A commit on the same edge as an accept reuses the register.
              if (!valid_o || ready_i) begin
                valid_o      <= 1'b1;
                dat_o        <= data_nxt;
                lchar_o      <= flag_q;
                parity_err_o <= perr_nxt;
              end else begin
                overrun_o <= 1'b1;
              end
            end
          end
          default: state <= ST_PAR;
        endcase
      end else if (state != ST_PAR) begin
        if (idle_left == 4'd0) begin
          abort_o   <= 1'b1;
          state     <= ST_PAR;
          idle_left <= IDLE_RELOAD;
        end else begin
          idle_left <= idle_left - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_ds_char.sv
// Bench for rx_ds_char: randomized and directed rail traffic checked against
// a character-level model (bit queue per partial character), plus literal
// expectations for the documented examples. Honors RX_PARITY_CHECK_EN.
module tb_rx_ds_char;

  localparam int IDLE_LIMIT = 4;
`ifdef RX_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Rx1 = 1'b0;
  logic       Rx0 = 1'b0;
  logic       ready_i = 1'b0;
  logic       valid_o;
  logic [7:0] dat_o;
  logic       lchar_o;
  logic       parity_err_o;
  logic       rail_err_o;
  logic       overrun_o;
  logic       abort_o;

  int total = 0;
  int bad = 0;
  int cnt_rail = 0;
  int cnt_ovr = 0;
  int cnt_abort = 0;

  rx_ds_char #(.IDLE_LIMIT(IDLE_LIMIT)) dut (
    .RxClk(clk), .RxReset(rst_n), .Rx1(Rx1), .Rx0(Rx0),
    .valid_o(valid_o), .ready_i(ready_i), .dat_o(dat_o), .lchar_o(lchar_o),
    .parity_err_o(parity_err_o), .rail_err_o(rail_err_o),
    .overrun_o(overrun_o), .abort_o(abort_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit         m1, m0;
  bit         q[$];
  int         idle;
  bit         e_valid, e_lchar, e_perr, e_rail, e_ovr, e_abort;
  logic [7:0] e_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = 0; m0 = 0; q.delete(); idle = 0;
      e_valid = 0; e_lchar = 0; e_perr = 0; e_dat = 0;
      e_rail = 0; e_ovr = 0; e_abort = 0;
    end else begin
      bit s1, s0;
      s1 = m1; s0 = m0;
      m1 = Rx1; m0 = Rx0;
      e_rail = 0; e_ovr = 0; e_abort = 0;
      if (e_valid && ready_i) e_valid = 0;
      if (s1 && s0) begin
        e_rail = 1; q.delete(); idle = 0;
      end else if (s1 != s0) begin
        idle = 0;
        q.push_back(s1);
        if (q.size() >= 2 && q.size() == (q[1] ? 4 : 10)) begin
          logic [7:0] d;
          bit x;
          d = 0;
          x = q[0];
          for (int i = 2; i < q.size(); i++) begin
            d[i-2] = q[i];
            x ^= q[i];
          end
          if (!e_valid) begin
            e_valid = 1; e_dat = d; e_lchar = q[1]; e_perr = PCHK && !x;
          end else begin
            e_ovr = 1;
          end
          q.delete();
        end
      end else if (q.size() > 0) begin
        idle++;
        if (idle == IDLE_LIMIT) begin
          e_abort = 1; q.delete(); idle = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: DUT vs model on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", {7'd0, valid_o}, {7'd0, e_valid});
      chk("rail_err", {7'd0, rail_err_o}, {7'd0, e_rail});
      chk("overrun", {7'd0, overrun_o}, {7'd0, e_ovr});
      chk("abort", {7'd0, abort_o}, {7'd0, e_abort});
      if (e_valid) begin
        chk("dat", dat_o, e_dat);
        chk("lchar", {7'd0, lchar_o}, {7'd0, e_lchar});
        chk("parity_err", {7'd0, parity_err_o}, {7'd0, e_perr});
      end
      if (rail_err_o) cnt_rail++;
      if (overrun_o) cnt_ovr++;
      if (abort_o) cnt_abort++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit b1, input bit b0, input bit rdy);
    Rx1 = b1; Rx0 = b0; ready_i = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic sbit(input bit b, input bit rdy);
    step(b, !b, rdy);
  endtask

  task automatic idle_n(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, rdy);
  endtask

  task automatic send_char(input bit fl, input logic [7:0] d, input bit p, input bit rdy);
    sbit(p, rdy);
    sbit(fl, rdy);
    for (int i = 0; i < (fl ? 2 : 8); i++) sbit(d[i], rdy);
  endtask

  function automatic bit good_par(input bit fl, input logic [7:0] d);
    return fl ? ~(d[0] ^ d[1]) : ~(^d);
  endfunction

  task automatic expect_char(input string tag, input logic [7:0] d, input bit fl, input bit pe);
    chk({tag, "_valid"}, {7'd0, valid_o}, 8'd1);
    chk({tag, "_dat"}, dat_o, d);
    chk({tag, "_lchar"}, {7'd0, lchar_o}, {7'd0, fl});
    chk({tag, "_perr"}, {7'd0, parity_err_o}, {7'd0, pe});
  endtask

  int c0;

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_valid", {7'd0, valid_o}, 8'd0);
    chk("rst_dat", dat_o, 8'd0);
    chk("rst_pulses", {5'd0, rail_err_o, overrun_o, abort_o}, 8'd0);
    idle_n(3, 1);

    // Normal 0xAA: rails 1,0,0,1,0,1,0,1,0,1
    send_char(0, 8'hAA, 1, 1);
    idle_n(1, 1);
    expect_char("aa", 8'hAA, 0, 0);
    idle_n(1, 1);
    chk("aa_accepted", {7'd0, valid_o}, 8'd0);

    // Link 0x02, one idle, link 0x00
    send_char(1, 8'h02, 0, 1);
    idle_n(1, 1);
    expect_char("l02", 8'h02, 1, 0);
    send_char(1, 8'h00, 1, 1);
    idle_n(1, 1);
    expect_char("l00", 8'h00, 1, 0);
    idle_n(2, 1);

    // Normal 0x55 with wrong parity 0
    send_char(0, 8'h55, 0, 1);
    idle_n(1, 1);
    expect_char("p55", 8'h55, 0, PCHK);
    idle_n(2, 1);

    // Partial 0xAA then IDLE_LIMIT idles, then link 0x01
    c0 = cnt_abort;
    sbit(1, 1); sbit(0, 1);
    sbit(0, 1); sbit(1, 1); sbit(0, 1); sbit(1, 1);
    idle_n(IDLE_LIMIT, 1);
    send_char(1, 8'h01, 0, 1);
    idle_n(1, 1);
    chk("abort_once", 8'(cnt_abort - c0), 8'd1);
    expect_char("l01", 8'h01, 1, 0);
    idle_n(2, 1);

    // Overrun: 0x11 then 0x22 back-to-back with ready low
    c0 = cnt_ovr;
    send_char(0, 8'h11, 1, 0);
    send_char(0, 8'h22, 1, 0);
    idle_n(2, 0);
    chk("ovr_once", 8'(cnt_ovr - c0), 8'd1);
    expect_char("hold11", 8'h11, 0, 0);
    idle_n(1, 1);
    chk("ovr_drained", {7'd0, valid_o}, 8'd0);
    idle_n(1, 1);

    // Rail error during DAT discards partial
    c0 = cnt_rail;
    sbit(1, 1); sbit(0, 1); sbit(1, 1); sbit(1, 1); sbit(0, 1);
    step(1, 1, 1);
    idle_n(2, 1);
    chk("rail_once", 8'(cnt_rail - c0), 8'd1);
    chk("rail_no_commit", {7'd0, valid_o}, 8'd0);
    send_char(1, 8'h03, 1, 1);
    idle_n(1, 1);
    expect_char("l03", 8'h03, 1, 0);
    idle_n(2, 1);

    // Asynchronous reset mid-character while valid_o is high
    send_char(0, 8'hAA, 1, 0);
    idle_n(1, 0);
    chk("pre_rst_valid", {7'd0, valid_o}, 8'd1);
    sbit(1, 0); sbit(0, 0); sbit(1, 0); sbit(1, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {7'd0, valid_o}, 8'd0);
    chk("arst_dat", dat_o, 8'd0);
    chk("arst_flags", {4'd0, lchar_o, parity_err_o, rail_err_o, overrun_o | abort_o}, 8'd0);
    Rx1 = 0; Rx0 = 0;
    idle_n(2, 1);
    rst_n = 1'b1;
    idle_n(1, 1);
    send_char(0, 8'h5A, 1, 1);
    idle_n(1, 1);
    expect_char("post_rst", 8'h5A, 0, 0);
    idle_n(2, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      bit rdy;
      r = $urandom_range(0, 99);
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 3) step(1, 1, rdy);
      else if (r < 13) idle_n($urandom_range(1, 6), rdy);
      else if (r < 20) begin
        logic [7:0] d;
        bit fl;
        d = 8'($urandom);
        fl = 1'($urandom);
        send_char(fl, d, good_par(fl, d), rdy);
      end else begin
        bit b;
        b = 1'($urandom);
        sbit(b, rdy);
      end
    end
    idle_n(4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_ds_char.md
# rx_ds_char

Character-level deserializer for the dual-rail serial link driven by `tx_DS_char`; it is the receive end of the same link. Each clock it samples the Rx1/Rx0 rail pair, where one high rail is one bit and both low is idle. It frames parity, flag and data bits into characters and presents each completed character through a one-entry valid/ready output register. It sits between the link pins and the link-layer character FIFO.

## Interface
- `IDLE_LIMIT`, default 4: consecutive idle cycles inside a partial character that abort it. Range 1..15.
- `RxClk`  in  1  receive clock. Rails are synchronous to it; the block has no synchronizer.
- `RxReset`  in  1  asynchronous, active-low reset.
- `Rx1`  in  1  rail: high = bit value 1.
- `Rx0`  in  1  rail: high = bit value 0.
- `valid_o`  out  1  output register holds a character.
- `ready_i`  in  1  consumer accepts the character on this edge when `valid_o` is high.
- `dat_o`  out  8  character data. For link characters, `[1:0]` carry data and `[7:2]` are 0.
- `lchar_o`  out  1  1 = link (control) character, 0 = normal data character.
- `parity_err_o`  out  1  parity mismatch for the held character.
- `rail_err_o`  out  1  one-cycle pulse: Rx1 and Rx0 were both high.
- `overrun_o`  out  1  one-cycle pulse: a completed character was dropped because the output register was full.
- `abort_o`  out  1  one-cycle pulse: a partial character was discarded on idle timeout.

## Operation
- Bit cycles:
  - Rx1 high, Rx0 low = bit 1.
  - Rx0 high, Rx1 low = bit 0.
  - Both low = idle; it does not advance framing.
  - Both high = rail error. `rail_err_o` pulses, the partial character is discarded, and the FSM returns to PAR.
- Character order: parity bit, flag bit, then data LSB first. Flag 0 is followed by 8 data bits. Flag 1 is followed by 2 data bits.
- Parity: the parity bit XOR all received data bits must equal 1. The flag is excluded. Examples:
  - Normal 0xAA carries parity 1.
  - Link 0x02 carries parity 0.
  - Link 0x00 carries parity 1.
- FSM states:
  - PAR: wait for the first bit, store it as parity, go to FLG.
  - FLG: store the flag, clear the bit counter, go to DAT.
  - DAT: shift bits in LSB first. On bit 8 (flag 0) or bit 2 (flag 1), commit and go to PAR.
- Idle counter: counts consecutive idle cycles while in FLG or DAT and clears on any bit cycle. Reaching `IDLE_LIMIT` pulses `abort_o` and returns to PAR. Idle cycles in PAR are unlimited.
- Commit:
  - If `valid_o` is 0, or `ready_i` is 1 on the same edge, load `dat_o`, `lchar_o` and `parity_err_o`; `valid_o` becomes 1.
  - Otherwise drop the character, pulse `overrun_o`, and leave the held character unchanged.
- Handshake: `valid_o` and the outputs stay stable until `valid_o && ready_i`. Acceptance without a simultaneous commit clears `valid_o` on the next edge.
- Reset: asynchronous, any time, including mid-character or while `valid_o` is high. All outputs go to 0, FSM to PAR, counters to 0. Bits arriving after reset deasserts start a new character at parity.

## Timing
- Rails are registered once before framing.
- The last data bit is on the rails in cycle N. `valid_o` is high after the edge ending cycle N+1.
- Back-to-back characters are permitted: a parity bit may arrive in the cycle right after the last data bit, and is processed in PAR with no lost cycle.
- Error pulses (`rail_err_o`, `overrun_o`, `abort_o`) are exactly one cycle wide and registered.
- Throughput is one bit per clock, so the minimum character period is 4 cycles (link) or 10 cycles (normal).

## Configuration
- `RX_PARITY_CHECK_EN`:
  - Defined: `parity_err_o` reflects the parity rule above for each committed character.
  - Undefined: the parity bit is consumed for framing only and `parity_err_o` is tied to 0.

## Test plan
- Normal 0xAA, driven as rails 1,0,0,1,0,1,0,1,0,1 with `ready_i`=1 → `valid_o` pulses once with `dat_o`=0xAA, `lchar_o`=0, `parity_err_o`=0.
- Link 0x02, then one idle, then link 0x00 (parity 1, flag 1, data 0,0) → two commits: `dat_o`=0x02 then 0x00, both with `lchar_o`=1 and no errors.
- Normal 0x55 sent with parity 0, with `RX_PARITY_CHECK_EN` defined → `parity_err_o`=1. With the macro undefined → `parity_err_o`=0.
- Partial character (parity, flag 0, D0..D3 of 0xAA), then `IDLE_LIMIT`=4 idle cycles, then link 0x01 → `abort_o` pulses once, followed by a clean commit of 0x01 with `lchar_o`=1.
- Hold `ready_i`=0 and send two normal characters, 0x11 then 0x22 → 0x11 stays held, `overrun_o` pulses when 0x22 completes, and 0x11 is delivered when `ready_i` rises.
- Rails both high during DAT → `rail_err_o` pulses and the partial character is discarded. Separately, assert `RxReset` low mid-character with `valid_o`=1 → all outputs are 0 immediately, and the next character decodes correctly.
